// File: rtl/axi_lite_pkg.sv
// Shared AXI4-lite constants and FSM state types for the lite RAM slave.
package axi_lite_pkg;

    localparam logic [1:0] resp_okay   = 2'b00;
    localparam logic [1:0] resp_slverr = 2'b10;
    localparam logic [1:0] resp_decerr = 2'b11;

    localparam logic [2:0] inst_prot = 3'b101;
    localparam logic [2:0] data_prot = 3'b000;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } r_state_t;

endpackage

// File: rtl/ram_bytewrite.sv
// Word-organised RAM with a 4-lane byte-enable write port and a registered read port.
module ram_bytewrite #(
    parameter  int DEPTH_WORDS = 1024,
    localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [3:0]       wr_be,
    input  logic [31:0]      wr_data,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_data
);

    logic [31:0] mem [DEPTH_WORDS];

    // A read and write to the same word on one edge returns the old contents.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/axi_lite_ram.sv
// AXI4-lite slave RAM with independent read/write channels and byte-strobed writes.
// Optional build macro PROT_CHECK_EN adds instruction-access protection checks.
module axi_lite_ram
    import axi_lite_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          EXEC_WORDS  = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddress,
    input  logic [2:0]  awprot,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wrstrb,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddress,
    input  logic [2:0]  arprot,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp
);

    localparam int          IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) * 33'd4;

    // Unsigned offset compare also catches addresses that wrap below the base.
    function automatic logic [1:0] decode_resp(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - ADDR_BASE;
        if ({1'b0, off} >= SPAN) return resp_decerr;
        if (off[1:0] != 2'b00) return resp_slverr;
        return resp_okay;
    endfunction

    function automatic logic [IDX_W-1:0] index_of(input logic [31:0] addr);
        return IDX_W'((addr - ADDR_BASE) >> 2);
    endfunction

    w_state_t    w_state, w_state_nxt;
    r_state_t    r_state, r_state_nxt;
    logic        aw_held, w_held;
    logic        aw_hs, w_hs, ar_hs, commit;
    logic [31:0] aw_addr_p1, w_data_p1;
    logic [3:0]  w_strb_p1;
    logic [1:0]  bresp_q, rresp_q;
    logic        rd_ok_p1;
    logic [1:0]  wr_resp_c, rd_resp_c;
    logic [31:0] ram_rdata;
    logic        unused_prot;

`ifdef PROT_CHECK_EN
    logic aw_inst_p1;

    // Decode errors win over protection errors.
    always_comb begin
        wr_resp_c = decode_resp(aw_addr_p1);
        if (wr_resp_c == resp_okay && aw_inst_p1) wr_resp_c = resp_slverr;
        rd_resp_c = decode_resp(araddress);
        if (rd_resp_c == resp_okay && arprot[2]
            && (32'(index_of(araddress)) >= 32'(EXEC_WORDS))) rd_resp_c = resp_slverr;
    end
    assign unused_prot = ^{awprot[1:0], arprot[1:0], inst_prot, data_prot};
`else
    assign wr_resp_c   = decode_resp(aw_addr_p1);
    assign rd_resp_c   = decode_resp(araddress);
    assign unused_prot = ^{awprot, arprot, inst_prot, data_prot, EXEC_WORDS};
`endif

    // Write channel: AW and W are captured independently, committed once both are held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) w_state <= W_IDLE;
        else        w_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = w_state;
        awready     = 1'b0;
        wready      = 1'b0;
        bvalid      = 1'b0;
        commit      = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready = !aw_held;
                wready  = !w_held;
                if (aw_held && w_held) begin
                    commit      = 1'b1;
                    w_state_nxt = W_RESP;
                end
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign bresp = bresp_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bresp_q <= resp_okay;
        end else begin
            if (aw_hs)       aw_held <= 1'b1;
            else if (commit) aw_held <= 1'b0;
            if (w_hs)        w_held  <= 1'b1;
            else if (commit) w_held  <= 1'b0;
            if (commit)      bresp_q <= wr_resp_c;
        end
    end

    always_ff @(posedge clk) begin
        if (aw_hs) begin
            aw_addr_p1 <= awaddress;
`ifdef PROT_CHECK_EN
            aw_inst_p1 <= awprot[2];
`endif
        end
        if (w_hs) begin
            w_data_p1 <= wdata;
            w_strb_p1 <= wrstrb;
        end
    end

    // Read channel: one-cycle latency, response held until rready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= R_IDLE;
        else        r_state <= r_state_nxt;
    end

    always_comb begin
        r_state_nxt = r_state;
        arready     = 1'b0;
        rvalid      = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid) r_state_nxt = R_RESP;
            end
            R_RESP: begin
                rvalid = 1'b1;
                if (rready) r_state_nxt = R_IDLE;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    assign ar_hs = arvalid && arready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rresp_q  <= resp_okay;
            rd_ok_p1 <= 1'b0;
        end else if (ar_hs) begin
            rresp_q  <= rd_resp_c;
            rd_ok_p1 <= (rd_resp_c == resp_okay);
        end
    end

    assign rresp = rresp_q;
    assign rdata = rd_ok_p1 ? ram_rdata : 32'h0;

    ram_bytewrite #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clk     (clk),
        .we      (commit && (wr_resp_c == resp_okay)),
        .wr_idx  (index_of(aw_addr_p1)),
        .wr_be   (w_strb_p1),
        .wr_data (w_data_p1),
        .rd_en   (ar_hs && (rd_resp_c == resp_okay)),
        .rd_idx  (index_of(araddress)),
        .rd_data (ram_rdata)
    );

endmodule
